bayer_rgb_binning: RTL and testbench
====================================

// Module: bayer_rgb_binning
// PURPOSE
//  Consumes the 12-bit raw Bayer stream and pixel/line coordinates from the CCD capture stage.
//  Bins each 2x2 Bayer quad into one RGB pixel using a one-line buffer, halving both dimensions.
//  For 1280 columns it produces 640-wide RGB. Output feeds the green-screen keyer / frame store.
// PARAMETERS
//  COLUMN_WIDTH  1280  raw pixels per line; line-buffer depth; must be even
//  DATA_W        12    raw and per-channel output width
//  ADDR_W        11    line-buffer address width; 2**ADDR_W >= COLUMN_WIDTH
// PORTS
//  iCLK       in   1       single clock, shared with capture stage
//  iRST       in   1       synchronous, active-high reset
//  iDATA      in   DATA_W  raw Bayer pixel, qualified by iDVAL
//  iDVAL      in   1       input pixel valid
//  iX_Cont    in   16      column of iDATA, 0..COLUMN_WIDTH-1
//  iY_Cont    in   16      row of iDATA, 0 at frame start
//  oRed       out  DATA_W  binned red
//  oGreen     out  DATA_W  binned green, average of G1 and G2
//  oBlue      out  DATA_W  binned blue
//  oDVAL      out  1       one-cycle strobe per RGB pixel
//  oX_Cont    out  15      output column = iX_Cont>>1
//  oY_Cont    out  15      output row = iY_Cont>>1
// BEHAVIOUR
//  Reset, checked on iCLK edge while iRST=1:
//   - all outputs and pipeline valids clear to 0
//   - line-buffer RAM contents are not cleared
//  Bayer phase, fixed:
//   - even row, even col = G1; even row, odd col = R
//   - odd row, even col = B; odd row, odd col = G2
//  Line buffer:
//   - each valid pixel is written at address iX_Cont[ADDR_W-1:0]
//   - the same address is read in the same cycle, read-before-write, 1-cycle latency
//   - read data is therefore the pixel one row above
//  Pipeline stage S1 (edge after input):
//   - registers cur=iDATA, up=RAM read, x, y, v=iDVAL
//  Pipeline stage S2:
//   - holds the previous S1 pair (cur_d, up_d), updated only when S1 v=1
//  Emit condition, evaluated on S1 values: v=1, x odd, y odd.
//   - on the next edge: oDVAL=1
//   - oRed=up; oBlue=cur_d
//   - oGreen=(up_d+cur)>>1, using a DATA_W+1-bit sum (no overflow; 4095+4095 -> 4095)
//   - oX_Cont=x>>1; oY_Cont=y>>1
//  Latency: an input pixel at (odd,odd) with iDVAL=1 at edge N gives oDVAL=1 at edge N+2.
//  oDVAL=0 on every other cycle; colour and coordinate outputs hold their last value.
//  Throughput: one RGB per 4 input pixels on a line pair; no back-pressure, no stall input.
//  Boundaries:
//   - row 0 (even): never emits; it only fills the buffer, so stale RAM from reset or an old frame is never output
//   - a new frame (iY_Cont back to 0) needs no special handling; the buffer is overwritten before use
//   - iDVAL gaps inside a line: pipeline pairs only valid pixels, so the quad stays correct across gaps
//   - iX_Cont >= COLUMN_WIDTH: the pixel is ignored (no write, no emit)
//   - iRST mid-line: the in-flight quad is discarded; the next output waits for the next odd row
// STRUCTURE
//  Shared package, bayer_pkg:
//   - DATA_W; COLUMN_WIDTH; phase constants PH_G1=2'b00, PH_R=2'b01, PH_B=2'b10, PH_G2=2'b11
//  Sub-module bayer_line_buffer:
//   - simple dual-port sync RAM, depth COLUMN_WIDTH, width DATA_W
//   - read-before-write, no reset; must infer block RAM
//  Top level: S1/S2 registers, emit logic, green adder.
// TESTING
//  1 Reset: hold iRST 3 cycles mid-stream -> all outputs 0, oDVAL 0; then 2 cycles with iDVAL=0 -> outputs stay 0.
//  2 Single quad (width 4):
//    - row0 = 100,200,.. ; row1 = 300,400,..
//    - expect oDVAL 2 cycles after (1,1) with R=200, B=300, G=250, oX=0, oY=0
//  3 Green saturation: G1=G2=4095 -> oGreen=4095; G1=4095, G2=0 -> oGreen=2047.
//  4 Full frame, COLUMN_WIDTH=1280, 960 rows, random data:
//    - exactly 640*480 oDVAL pulses
//    - every RGB matches the reference model
//    - row 0 produces 0 pulses
//  5 iDVAL gaps: random 0-3-cycle gaps inside lines -> outputs identical to gap-free run, latency from the last quad pixel still 2.
//  6 Two frames, frame 1 data != frame 0 -> frame-1 outputs use no frame-0 values; iX_Cont=1280 injected -> no emit, no corruption.

Source files
------------

// File: rtl/bayer_pkg.sv
// Shared definitions for the Bayer 2x2 binning pipeline.
//   DATA_W        raw pixel / output channel width
//   COLUMN_WIDTH  raw pixels per line (line-buffer depth)
//   phase_e       fixed Bayer phase selected by {row[0], col[0]}
package bayer_pkg;

    localparam int DATA_W       = 12;
    localparam int COLUMN_WIDTH = 1280;

    typedef enum logic [1:0] {
        PH_G1 = 2'b00,  // even row, even col
        PH_R  = 2'b01,  // even row, odd col
        PH_B  = 2'b10,  // odd row, even col
        PH_G2 = 2'b11   // odd row, odd col
    } phase_e;

    function automatic phase_e bayer_phase(input logic row_lsb, input logic col_lsb);
        return phase_e'({row_lsb, col_lsb});
    endfunction

endpackage

// File: rtl/bayer_line_buffer.sv
// One-line pixel buffer: single-address, read-before-write sync RAM, no reset.
//   clk_i    clock
//   en_i     access enable (read old word and write new word at addr_i)
//   addr_i   column address
//   wdata_i  pixel to store
//   rdata_o  word previously stored at addr_i, one cycle later
module bayer_line_buffer #(
    parameter int DEPTH  = 1280,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read and write in the same block so the read returns the old word.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q        <= mem_q[addr_i];
            mem_q[addr_i]  <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bayer_rgb_binning.sv
// Bins each 2x2 Bayer quad (G1 R / B G2) into one RGB pixel, halving both
// dimensions, using a one-line buffer for the row above.
//   iCLK, iRST            clock, synchronous active-high reset
//   iDATA, iDVAL          raw pixel and its valid
//   iX_Cont, iY_Cont      raw column / row of iDATA
//   oRed, oGreen, oBlue   binned colour (green = mean of G1 and G2)
//   oDVAL                 one-cycle strobe per RGB pixel
//   oX_Cont, oY_Cont      output column / row (raw coordinates >> 1)
module bayer_rgb_binning #(
    parameter int COLUMN_WIDTH = bayer_pkg::COLUMN_WIDTH,
    parameter int DATA_W       = bayer_pkg::DATA_W,
    parameter int ADDR_W       = 11
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [15:0]       iX_Cont,
    input  logic [15:0]       iY_Cont,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL,
    output logic [14:0]       oX_Cont,
    output logic [14:0]       oY_Cont
);

    import bayer_pkg::*;

    localparam logic [15:0] COL_LIMIT = 16'(COLUMN_WIDTH);

    logic              in_ok;
    logic [DATA_W-1:0] up_rd;

    // S1: current pixel, coordinates, valid (RAM output aligns with this stage)
    logic [DATA_W-1:0] cur_q;
    logic [15:0]       x_q;
    logic [15:0]       y_q;
    logic              v_q;
    // S2: previous valid S1 pair
    logic [DATA_W-1:0] cur_p_q;
    logic [DATA_W-1:0] up_p_q;
    // Set once an even row has been seen since reset; blocks emitting a
    // quad whose left half or upper row was lost to a mid-line reset.
    logic              arm_q;

    logic              emit_d;
    logic [DATA_W:0]   green_sum;

    assign in_ok = iDVAL && (iX_Cont < COL_LIMIT);

    bayer_line_buffer #(
        .DEPTH  (COLUMN_WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lbuf (
        .clk_i   (iCLK),
        .en_i    (in_ok),
        .addr_i  (iX_Cont[ADDR_W-1:0]),
        .wdata_i (iDATA),
        .rdata_o (up_rd)
    );

    always_comb begin
        emit_d    = v_q && arm_q && (bayer_phase(y_q[0], x_q[0]) == PH_G2);
        green_sum = {1'b0, up_p_q} + {1'b0, cur_q};
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cur_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            v_q     <= 1'b0;
            cur_p_q <= '0;
            up_p_q  <= '0;
            arm_q   <= 1'b0;
            oDVAL   <= 1'b0;
            oRed    <= '0;
            oGreen  <= '0;
            oBlue   <= '0;
            oX_Cont <= '0;
            oY_Cont <= '0;
        end else begin
            cur_q <= iDATA;
            x_q   <= iX_Cont;
            y_q   <= iY_Cont;
            v_q   <= in_ok;

            if (v_q) begin
                cur_p_q <= cur_q;
                up_p_q  <= up_rd;
                if (!y_q[0]) begin
                    arm_q <= 1'b1;
                end
            end

            oDVAL <= emit_d;
            if (emit_d) begin
                oRed    <= up_rd;
                oBlue   <= cur_p_q;
                oGreen  <= green_sum[DATA_W:1];
                oX_Cont <= x_q[15:1];
                oY_Cont <= y_q[15:1];
            end
        end
    end

endmodule

// File: tb/tb_bayer_rgb_binning.sv
module tb_bayer_rgb_binning;

    logic        clk = 1'b0;
    logic        iRST;
    logic [11:0] iDATA;
    logic        iDVAL;
    logic [15:0] iX_Cont;
    logic [15:0] iY_Cont;
    logic [11:0] oRed;
    logic [11:0] oGreen;
    logic [11:0] oBlue;
    logic        oDVAL;
    logic [14:0] oX_Cont;
    logic [14:0] oY_Cont;

    always #5 clk = ~clk;

    bayer_rgb_binning #(
        .COLUMN_WIDTH (1280),
        .DATA_W       (12),
        .ADDR_W       (11)
    ) dut (
        .iCLK    (clk),
        .iRST    (iRST),
        .iDATA   (iDATA),
        .iDVAL   (iDVAL),
        .iX_Cont (iX_Cont),
        .iY_Cont (iY_Cont),
        .oRed    (oRed),
        .oGreen  (oGreen),
        .oBlue   (oBlue),
        .oDVAL   (oDVAL),
        .oX_Cont (oX_Cont),
        .oY_Cont (oY_Cont)
    );

    typedef struct {
        logic [11:0] r;
        logic [11:0] g;
        logic [11:0] b;
        logic [14:0] x;
        logic [14:0] y;
        int          c;
    } out_t;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    out_t        mon_q[$];
    int          drv_q[$];
    logic [11:0] img [0:1][0:7][0:1279];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output strobe together with the cycle it appeared.
    always @(negedge clk) begin
        if (oDVAL === 1'b1)
            mon_q.push_back('{r: oRed, g: oGreen, b: oBlue, x: oX_Cont, y: oY_Cont, c: cyc});
    end

    task automatic drive_pix(input int x, input int y, input logic [11:0] d, input logic v);
        @(negedge clk);
        iDATA   = d;
        iDVAL   = v;
        iX_Cont = 16'(x);
        iY_Cont = 16'(y);
        if (v && (x % 2 == 1) && (y % 2 == 1) && x < 1280)
            drv_q.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            iDVAL = 1'b0;
            iDATA = 12'($urandom_range(4095, 0));
        end
    endtask

    task automatic drive_row(input int f, input int y, input int cols, input int maxgap);
        for (int x = 0; x < cols; x++) begin
            drive_pix(x, y, img[f][y][x], 1'b1);
            if (maxgap > 0) idle($urandom_range(maxgap, 0));
        end
        idle(2);
    endtask

    task automatic test_reset();
        iRST = 1'b1; iDVAL = 1'b0; iDATA = '0; iX_Cont = '0; iY_Cont = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (oDVAL !== 1'b0) begin
            errors++; $display("FAIL reset_dval got %b exp 0", oDVAL);
        end
        checks++;
        if ({oRed, oGreen, oBlue, oX_Cont, oY_Cont} !== 66'd0) begin
            errors++; $display("FAIL reset_outputs got r=%0d g=%0d b=%0d x=%0d y=%0d exp all 0",
                               oRed, oGreen, oBlue, oX_Cont, oY_Cont);
        end
        iRST = 1'b0;
        idle(2);
        checks++;
        if ({oDVAL, oRed, oGreen, oBlue, oX_Cont, oY_Cont} !== 67'd0) begin
            errors++; $display("FAIL reset_idle got dval=%b r=%0d g=%0d b=%0d exp all 0",
                               oDVAL, oRed, oGreen, oBlue);
        end
    endtask

    task automatic test_single_quad();
        for (int x = 0; x < 4; x++) begin
            img[0][0][x] = 12'(100 * (x + 1));
            img[0][1][x] = 12'(100 * (x + 3));
        end
        mon_q.delete(); drv_q.delete();
        drive_row(0, 0, 4, 0);
        drive_row(0, 1, 4, 0);
        idle(3);
        checks++;
        if (mon_q.size() != 2) begin
            errors++; $display("FAIL quad_count got %0d exp 2", mon_q.size());
        end else begin
            checks++;
            if ({mon_q[0].r, mon_q[0].g, mon_q[0].b, mon_q[0].x, mon_q[0].y} !==
                {12'd200, 12'd250, 12'd300, 15'd0, 15'd0}) begin
                errors++; $display("FAIL quad0 got r=%0d g=%0d b=%0d x=%0d y=%0d exp 200 250 300 0 0",
                                   mon_q[0].r, mon_q[0].g, mon_q[0].b, mon_q[0].x, mon_q[0].y);
            end
            checks++;
            if ({mon_q[1].r, mon_q[1].g, mon_q[1].b, mon_q[1].x, mon_q[1].y} !==
                {12'd400, 12'd450, 12'd500, 15'd1, 15'd0}) begin
                errors++; $display("FAIL quad1 got r=%0d g=%0d b=%0d x=%0d y=%0d exp 400 450 500 1 0",
                                   mon_q[1].r, mon_q[1].g, mon_q[1].b, mon_q[1].x, mon_q[1].y);
            end
            checks++;
            if (mon_q[0].c - drv_q[0] != 2) begin
                errors++; $display("FAIL quad_latency got %0d exp 2", mon_q[0].c - drv_q[0]);
            end
        end
        checks++;
        if ({oDVAL, oRed, oBlue} !== {1'b0, 12'd400, 12'd500}) begin
            errors++; $display("FAIL quad_hold got dval=%b r=%0d b=%0d exp 0 400 500", oDVAL, oRed, oBlue);
        end
    endtask

    task automatic test_green_sat();
        img[0][0][0] = 12'd4095; img[0][0][1] = 12'd10; img[0][0][2] = 12'd4095; img[0][0][3] = 12'd20;
        img[0][1][0] = 12'd30;   img[0][1][1] = 12'd4095; img[0][1][2] = 12'd40; img[0][1][3] = 12'd0;
        mon_q.delete();
        drive_row(0, 0, 4, 0);
        drive_row(0, 1, 4, 0);
        idle(3);
        checks++;
        if (mon_q.size() != 2) begin
            errors++; $display("FAIL sat_count got %0d exp 2", mon_q.size());
        end else begin
            checks++;
            if ({mon_q[0].r, mon_q[0].g, mon_q[0].b} !== {12'd10, 12'd4095, 12'd30}) begin
                errors++; $display("FAIL sat_full got r=%0d g=%0d b=%0d exp 10 4095 30",
                                   mon_q[0].r, mon_q[0].g, mon_q[0].b);
            end
            checks++;
            if ({mon_q[1].r, mon_q[1].g, mon_q[1].b} !== {12'd20, 12'd2047, 12'd40}) begin
                errors++; $display("FAIL sat_half got r=%0d g=%0d b=%0d exp 20 2047 40",
                                   mon_q[1].r, mon_q[1].g, mon_q[1].b);
            end
        end
    endtask

    task automatic test_reset_midline();
        for (int x = 0; x < 4; x++) begin
            img[0][0][x] = 12'(11 + x);
            img[0][1][x] = 12'(21 + x);
            img[0][2][x] = 12'(31 + x);
            img[0][3][x] = 12'(41 + x);
        end
        mon_q.delete();
        drive_row(0, 0, 4, 0);
        for (int x = 0; x < 3; x++) drive_pix(x, 1, img[0][1][x], 1'b1);
        @(negedge clk);
        iRST = 1'b1;
        repeat (3) drive_pix(3, 1, img[0][1][3], 1'b1);
        @(negedge clk);
        checks++;
        if ({oDVAL, oRed, oGreen, oBlue, oX_Cont, oY_Cont} !== 67'd0) begin
            errors++; $display("FAIL midreset_outputs got dval=%b r=%0d g=%0d b=%0d exp all 0",
                               oDVAL, oRed, oGreen, oBlue);
        end
        iRST = 1'b0;
        idle(2);
        checks++;
        if ({oDVAL, oRed, oGreen, oBlue} !== 37'd0) begin
            errors++; $display("FAIL midreset_idle got dval=%b r=%0d exp 0 0", oDVAL, oRed);
        end
        mon_q.delete();
        drive_pix(3, 1, img[0][1][3], 1'b1);
        idle(3);
        checks++;
        if (mon_q.size() != 0) begin
            errors++; $display("FAIL midreset_discard got %0d pulses exp 0", mon_q.size());
        end
        drive_row(0, 2, 4, 0);
        drive_row(0, 3, 4, 0);
        idle(3);
        checks++;
        if (mon_q.size() != 2) begin
            errors++; $display("FAIL midreset_resume_count got %0d exp 2", mon_q.size());
        end else begin
            checks++;
            if ({mon_q[0].r, mon_q[0].g, mon_q[0].b, mon_q[0].x, mon_q[0].y} !==
                {12'd32, 12'd36, 12'd41, 15'd0, 15'd1}) begin
                errors++; $display("FAIL midreset_q0 got r=%0d g=%0d b=%0d x=%0d y=%0d exp 32 36 41 0 1",
                                   mon_q[0].r, mon_q[0].g, mon_q[0].b, mon_q[0].x, mon_q[0].y);
            end
            checks++;
            if ({mon_q[1].r, mon_q[1].g, mon_q[1].b, mon_q[1].x, mon_q[1].y} !==
                {12'd34, 12'd38, 12'd43, 15'd1, 15'd1}) begin
                errors++; $display("FAIL midreset_q1 got r=%0d g=%0d b=%0d x=%0d y=%0d exp 34 38 43 1 1",
                                   mon_q[1].r, mon_q[1].g, mon_q[1].b, mon_q[1].x, mon_q[1].y);
            end
        end
    endtask

    task automatic test_full_frame();
        int n;
        int nerr;
        logic [11:0] er, eg, eb;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 1280; x++)
                img[0][y][x] = 12'($urandom_range(4095, 0));
        mon_q.delete();
        drive_row(0, 0, 1280, 0);
        idle(3);
        checks++;
        if (mon_q.size() != 0) begin
            errors++; $display("FAIL full_row0 got %0d pulses exp 0", mon_q.size());
        end
        for (int y = 1; y < 8; y++) drive_row(0, y, 1280, 0);
        idle(3);
        checks++;
        if (mon_q.size() != 2560) begin
            errors++; $display("FAIL full_count got %0d exp 2560", mon_q.size());
        end
        n = 0; nerr = 0;
        for (int y = 1; y < 8; y += 2) begin
            for (int x = 1; x < 1280; x += 2) begin
                if (n < mon_q.size() && nerr < 10) begin
                    er = img[0][y-1][x];
                    eb = img[0][y][x-1];
                    eg = 12'((int'(img[0][y-1][x-1]) + int'(img[0][y][x])) >> 1);
                    checks++;
                    if ({mon_q[n].r, mon_q[n].g, mon_q[n].b, mon_q[n].x, mon_q[n].y} !==
                        {er, eg, eb, 15'(x >> 1), 15'(y >> 1)}) begin
                        errors++; nerr++;
                        $display("FAIL full_pix[%0d] got r=%0d g=%0d b=%0d x=%0d y=%0d exp %0d %0d %0d %0d %0d",
                                 n, mon_q[n].r, mon_q[n].g, mon_q[n].b, mon_q[n].x, mon_q[n].y,
                                 er, eg, eb, x >> 1, y >> 1);
                    end
                end
                n++;
            end
        end
    endtask

    task automatic test_gaps();
        int n;
        int nerr;
        logic [11:0] er, eg, eb;
        mon_q.delete(); drv_q.delete();
        for (int y = 0; y < 4; y++) drive_row(0, y, 1280, 3);
        idle(3);
        checks++;
        if (mon_q.size() != 1280 || drv_q.size() != 1280) begin
            errors++; $display("FAIL gaps_count got %0d outs %0d quads exp 1280", mon_q.size(), drv_q.size());
        end
        n = 0; nerr = 0;
        for (int y = 1; y < 4; y += 2) begin
            for (int x = 1; x < 1280; x += 2) begin
                if (n < mon_q.size() && n < drv_q.size() && nerr < 10) begin
                    er = img[0][y-1][x];
                    eb = img[0][y][x-1];
                    eg = 12'((int'(img[0][y-1][x-1]) + int'(img[0][y][x])) >> 1);
                    checks++;
                    if ({mon_q[n].r, mon_q[n].g, mon_q[n].b, mon_q[n].x, mon_q[n].y} !==
                        {er, eg, eb, 15'(x >> 1), 15'(y >> 1)}) begin
                        errors++; nerr++;
                        $display("FAIL gaps_pix[%0d] got r=%0d g=%0d b=%0d exp %0d %0d %0d",
                                 n, mon_q[n].r, mon_q[n].g, mon_q[n].b, er, eg, eb);
                    end
                    checks++;
                    if (mon_q[n].c - drv_q[n] != 2) begin
                        errors++; nerr++;
                        $display("FAIL gaps_latency[%0d] got %0d exp 2", n, mon_q[n].c - drv_q[n]);
                    end
                end
                n++;
            end
        end
    endtask

    task automatic test_two_frames();
        int n;
        int nerr;
        logic [11:0] er, eg, eb;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 16; x++) begin
                img[0][y][x] = 12'($urandom_range(2047, 0));
                img[1][y][x] = 12'($urandom_range(4095, 2048));
            end
        end
        mon_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < 4; y++) begin
                if (f == 1 && y == 1) begin
                    for (int x = 0; x < 16; x++) begin
                        drive_pix(x, 1, img[1][1][x], 1'b1);
                        if (x == 2) begin
                            drive_pix(1280, 1, 12'd0, 1'b1);
                            drive_pix(1281, 1, 12'd0, 1'b1);
                        end
                    end
                    idle(2);
                end else begin
                    drive_row(f, y, 16, 0);
                end
            end
        end
        idle(3);
        checks++;
        if (mon_q.size() != 32) begin
            errors++; $display("FAIL frames_count got %0d exp 32", mon_q.size());
        end
        n = 0; nerr = 0;
        for (int f = 0; f < 2; f++) begin
            for (int y = 1; y < 4; y += 2) begin
                for (int x = 1; x < 16; x += 2) begin
                    if (n < mon_q.size() && nerr < 10) begin
                        er = img[f][y-1][x];
                        eb = img[f][y][x-1];
                        eg = 12'((int'(img[f][y-1][x-1]) + int'(img[f][y][x])) >> 1);
                        checks++;
                        if ({mon_q[n].r, mon_q[n].g, mon_q[n].b, mon_q[n].x, mon_q[n].y} !==
                            {er, eg, eb, 15'(x >> 1), 15'(y >> 1)}) begin
                            errors++; nerr++;
                            $display("FAIL frames_pix[f%0d,%0d] got r=%0d g=%0d b=%0d x=%0d exp %0d %0d %0d %0d",
                                     f, n, mon_q[n].r, mon_q[n].g, mon_q[n].b, mon_q[n].x,
                                     er, eg, eb, x >> 1);
                        end
                    end
                    n++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_quad();
        test_green_sat();
        test_reset_midline();
        test_full_frame();
        test_gaps();
        test_two_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
